// File: rtl/ndn_interest_rx.sv
`default_nettype none
// ============================================================================
// Module      : ndn_interest_rx
// Description : Receives an NDN interest byte stream (header + MSB-first
//               prefix bytes), assembles a right-aligned, length-masked name
//               prefix and strobes it to the router. Bad headers and
//               inter-byte timeouts drop the frame with an err strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module ndn_interest_rx #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,        // asynchronous, active-low
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [63:0] prefix,
    output logic [5:0]  len,
    output logic        out_bit,
    output logic        err
);

    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] c_TIMEOUT = IW'(TIMEOUT);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_COLLECT = 2'd1;
    localparam logic [1:0] c_EMIT    = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [55:0]   shift_q,   shift_d;
    logic [3:0]    cnt_q,     cnt_d;
    logic [IW-1:0] idle_q,    idle_d;
    logic [5:0]    len_lat_q, len_lat_d;
    logic          rx_ready_q, rx_ready_d;
    logic [63:0]   prefix_q,  prefix_d;
    logic [5:0]    len_q,     len_d;
    logic          out_bit_q, out_bit_d;
    logic          err_q,     err_d;

    logic          w_xfer;
    logic          w_hdr_ok;
    logic [63:0]   w_full;
    logic [63:0]   w_mask;
    logic [IW-1:0] w_idle_inc;

    assign w_xfer     = rx_valid && rx_ready_q;
    assign w_hdr_ok   = (rx_byte[7:6] == 2'b00) && (rx_byte[5:0] != 6'd0);
    // The incoming byte completes the shift register image; on the last byte
    // this is exactly the prefix before masking.
    assign w_full     = {shift_q, rx_byte};
    assign w_mask     = (64'd1 << len_lat_q) - 64'd1;
    assign w_idle_inc = idle_q + {{(IW-1){1'b0}}, 1'b1};

    // Next-state logic: header decode, byte collection, timeout and emit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        idle_d    = idle_q;
        len_lat_d = len_lat_q;
        prefix_d  = prefix_q;
        len_d     = len_q;
        out_bit_d = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (w_xfer) begin
                    if (w_hdr_ok) begin
                        state_d   = c_COLLECT;
                        len_lat_d = rx_byte[5:0];
                        cnt_d     = 4'(({1'b0, rx_byte[5:0]} + 7'd7) >> 3);
                        shift_d   = 56'd0;
                        idle_d    = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            c_COLLECT: begin
                if (w_xfer) begin
                    shift_d = w_full[55:0];
                    cnt_d   = cnt_q - 4'd1;
                    idle_d  = '0;
                    if (cnt_q == 4'd1) begin
                        // Outputs are loaded now so they appear in the EMIT cycle.
                        state_d   = c_EMIT;
                        prefix_d  = w_full & w_mask;
                        len_d     = len_lat_q;
                        out_bit_d = 1'b1;
                    end
                end else begin
                    idle_d = w_idle_inc;
                    if (w_idle_inc == c_TIMEOUT) begin
                        state_d = c_IDLE;
                        idle_d  = '0;
                        cnt_d   = 4'd0;
                        err_d   = 1'b1;
                    end
                end
            end
            c_EMIT: begin
                state_d = c_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
        // Ready is registered; it drops exactly for the EMIT cycle.
        rx_ready_d = (state_d != c_EMIT);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= c_IDLE;
            shift_q    <= 56'd0;
            cnt_q      <= 4'd0;
            idle_q     <= '0;
            len_lat_q  <= 6'd0;
            rx_ready_q <= 1'b0;
            prefix_q   <= 64'd0;
            len_q      <= 6'd0;
            out_bit_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            len_lat_q  <= len_lat_d;
            rx_ready_q <= rx_ready_d;
            prefix_q   <= prefix_d;
            len_q      <= len_d;
            out_bit_q  <= out_bit_d;
            err_q      <= err_d;
        end
    end

    assign rx_ready = rx_ready_q;
    assign prefix   = prefix_q;
    assign len      = len_q;
    assign out_bit  = out_bit_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ndn_interest_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ndn_interest_rx
// Description : Self-checking bench for ndn_interest_rx. A frame-level
//               reference model predicts every output each cycle; directed
//               frames add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ndn_interest_rx;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [63:0] prefix;
    logic [5:0]  len;
    logic        out_bit;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int err_cnt = 0;
    int out_cnt = 0;

    ndn_interest_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .prefix   (prefix),
        .len      (len),
        .out_bit  (out_bit),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame level) ----------------
    logic        exp_ready, exp_out, exp_err;
    logic [63:0] exp_prefix;
    logic [5:0]  exp_len;
    bit          in_frame, emit_cycle;
    int          need, idle;
    logic [5:0]  m_len;
    logic [63:0] acc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_ready = 0; exp_out = 0; exp_err = 0;
            exp_prefix = 0; exp_len = 0;
            in_frame = 0; emit_cycle = 0; need = 0; idle = 0; acc = 0; m_len = 0;
        end else begin
            bit xfer;
            xfer = rx_valid && exp_ready;
            exp_out = 0;
            exp_err = 0;
            if (emit_cycle) begin
                emit_cycle = 0;
            end else if (!in_frame) begin
                if (xfer) begin
                    if (rx_byte[7:6] == 2'b00 && rx_byte[5:0] != 0) begin
                        in_frame = 1;
                        m_len = rx_byte[5:0];
                        need = (int'(m_len) + 7) / 8;
                        acc = 0;
                        idle = 0;
                    end else begin
                        exp_err = 1;
                    end
                end
            end else if (xfer) begin
                acc = acc * 256 + 64'(rx_byte);
                need--;
                idle = 0;
                if (need == 0) begin
                    logic [64:0] modv;
                    modv = 65'd1 << m_len;
                    exp_prefix = 64'({1'b0, acc} % modv);
                    exp_len = m_len;
                    exp_out = 1;
                    in_frame = 0;
                    emit_cycle = 1;
                end
            end else begin
                idle++;
                if (idle == TIMEOUT) begin
                    exp_err = 1;
                    in_frame = 0;
                end
            end
            exp_ready = !emit_cycle;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("rx_ready", 64'(rx_ready), 64'(exp_ready));
        chk("out_bit",  64'(out_bit),  64'(exp_out));
        chk("err",      64'(err),      64'(exp_err));
        chk("prefix",   prefix,        exp_prefix);
        chk("len",      64'(len),      64'(exp_len));
        if (out_bit && err) chk("strobe_overlap", 64'd1, 64'd0);
        if (err) err_cnt++;
        if (out_bit) out_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("ready_wait_timeout", 64'd0, 64'd1);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_bit && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_bit) chk("out_bit_wait_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int e0, o0;
        repeat (3) @(negedge clk);
        chk("lit_reset_ready",  64'(rx_ready), 64'd0);
        chk("lit_reset_prefix", prefix,        64'd0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("lit_ready_after_reset", 64'(rx_ready), 64'd1);

        // Single byte, latency: out_bit in the cycle right after the byte.
        send(8'h05); send(8'h1C);
        chk("lit_latency_out_bit", 64'(out_bit), 64'd1);
        chk("lit_p28", prefix, 64'd28);
        chk("lit_len5", 64'(len), 64'd5);
        idle_cycles(2);

        // Masking above L.
        send(8'h05); send(8'hFC); wait_out();
        chk("lit_mask", prefix, 64'h1C);
        idle_cycles(1);

        // Idle gaps inside a frame.
        e0 = err_cnt;
        send(8'h10); send(8'hAB); idle_cycles(3); send(8'hCD); wait_out();
        chk("lit_abcd", prefix, 64'hABCD);
        chk("lit_len16", 64'(len), 64'd16);
        chk("lit_gap_no_err", 64'(err_cnt - e0), 64'd0);
        idle_cycles(1);

        // Transfer on the cycle the idle counter would hit TIMEOUT wins.
        e0 = err_cnt;
        send(8'h10); send(8'h12); idle_cycles(TIMEOUT - 1); send(8'h34); wait_out();
        chk("lit_boundary_prefix", prefix, 64'h1234);
        chk("lit_boundary_no_err", 64'(err_cnt - e0), 64'd0);
        idle_cycles(1);

        // Longest prefix; ready low during EMIT.
        send(8'h3F);
        for (int i = 0; i < 8; i++) send(8'hFF);
        chk("lit_emit_out", 64'(out_bit), 64'd1);
        chk("lit_emit_ready_low", 64'(rx_ready), 64'd0);
        chk("lit_p63", prefix, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("lit_len63", 64'(len), 64'd63);
        // Header offered during EMIT must wait for ready.
        send(8'h08); send(8'hA5); wait_out();
        chk("lit_back_to_back", prefix, 64'hA5);
        idle_cycles(1);

        // Bad headers.
        e0 = err_cnt; o0 = out_cnt;
        send(8'h00); send(8'h45); idle_cycles(2);
        chk("lit_bad_hdr_errs", 64'(err_cnt - e0), 64'd2);
        chk("lit_bad_hdr_no_out", 64'(out_cnt - o0), 64'd0);
        chk("lit_bad_hdr_prefix_kept", prefix, 64'hA5);
        chk("lit_bad_hdr_len_kept", 64'(len), 64'd8);

        // Timeout abort, then a clean frame.
        e0 = err_cnt; o0 = out_cnt;
        send(8'h10); send(8'hAB); idle_cycles(TIMEOUT);
        chk("lit_timeout_err_now", 64'(err), 64'd1);
        idle_cycles(2);
        chk("lit_timeout_one_err", 64'(err_cnt - e0), 64'd1);
        chk("lit_timeout_no_out", 64'(out_cnt - o0), 64'd0);
        send(8'h08); send(8'h5A); wait_out();
        chk("lit_after_timeout", prefix, 64'h5A);
        idle_cycles(1);

        // Reset mid-frame.
        e0 = err_cnt; o0 = out_cnt;
        send(8'h10); send(8'hAB);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("lit_rst_prefix", prefix, 64'd0);
        chk("lit_rst_len", 64'(len), 64'd0);
        chk("lit_rst_ready", 64'(rx_ready), 64'd0);
        #2 rst = 1'b1;
        idle_cycles(TIMEOUT + 4);
        chk("lit_rst_no_err", 64'(err_cnt - e0), 64'd0);
        chk("lit_rst_no_out", 64'(out_cnt - o0), 64'd0);
        chk("lit_rst_ready_back", 64'(rx_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
